// File: rtl/instr_register_param.sv
// DEPTH-entry opcode/operand register file with write-time result computation,
// per-entry valid bits, auto write pointer and a registered read port. Define INSTR_REG_RESULT_EN to build the result path.
module instr_register_param #(
   parameter int unsigned  DEPTH     = 32,
   parameter int unsigned  OP_WIDTH  = 32,
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic                    auto_inc,
   input  logic [PTR_WIDTH-1:0]    write_pointer,
   input  logic [PTR_WIDTH-1:0]    read_pointer,
   input  logic [3:0]              opcode,
   input  logic [OP_WIDTH-1:0]     operand_a,
   input  logic [OP_WIDTH-1:0]     operand_b,
   output logic [3:0]              rd_opcode,
   output logic [OP_WIDTH-1:0]     rd_operand_a,
   output logic [OP_WIDTH-1:0]     rd_operand_b,
   output logic [2*OP_WIDTH-1:0]   rd_result,
   output logic                    rd_valid,
   output logic                    rd_illegal,
   output logic [PTR_WIDTH-1:0]    next_wr_ptr,
   output logic [PTR_WIDTH:0]      wr_count
);

   localparam int unsigned         CW       = PTR_WIDTH + 1;
   localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

   logic [3:0]          op_mem  [DEPTH];
   logic [OP_WIDTH-1:0] a_mem   [DEPTH];
   logic [OP_WIDTH-1:0] b_mem   [DEPTH];
   logic                ill_mem [DEPTH];
   logic [DEPTH-1:0]    valid;

   logic [PTR_WIDTH-1:0] wr_addr;
   logic                 wr_in_range;
   logic                 rd_in_range;
   logic                 wr_fire;
   logic                 wr_hit;
   logic                 illegal_c;

   logic [3:0]           rd_op_n;
   logic [OP_WIDTH-1:0]  rd_a_n;
   logic [OP_WIDTH-1:0]  rd_b_n;
   logic                 rd_val_n;
   logic                 rd_ill_n;

   // Address selection; a write on a reset edge or to an address beyond DEPTH is dropped
   assign wr_addr     = auto_inc ? next_wr_ptr : write_pointer;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
   assign rd_in_range = {1'b0, read_pointer} < DEPTH_C;
   assign wr_fire     = load_en & ~reset & wr_in_range;
   assign wr_hit      = wr_fire & (wr_addr == read_pointer);
   assign illegal_c   = opcode[3];

   // Entry storage is not reset; the valid bits mask stale contents
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         op_mem[wr_addr]  <= opcode;
         a_mem[wr_addr]   <= operand_a;
         b_mem[wr_addr]   <= operand_b;
         ill_mem[wr_addr] <= illegal_c;
      end
   end

   // Valid bits, auto pointer and count of valid entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid       <= '0;
         next_wr_ptr <= '0;
         wr_count    <= '0;
      end else if (wr_fire) begin
         valid[wr_addr] <= 1'b1;
         if (!valid[wr_addr]) begin
            wr_count <= wr_count + CW'(1);
         end
         if (auto_inc) begin
            next_wr_ptr <= (next_wr_ptr == LAST_PTR) ? '0 : next_wr_ptr + PTR_WIDTH'(1);
         end
      end
   end

   // Read selection with write-through for a same-address write
   always_comb begin
      rd_op_n  = '0;
      rd_a_n   = '0;
      rd_b_n   = '0;
      rd_val_n = 1'b0;
      rd_ill_n = 1'b0;
      if (wr_hit) begin
         rd_op_n  = opcode;
         rd_a_n   = operand_a;
         rd_b_n   = operand_b;
         rd_val_n = 1'b1;
         rd_ill_n = illegal_c;
      end else if (rd_in_range && valid[read_pointer]) begin
         rd_op_n  = op_mem[read_pointer];
         rd_a_n   = a_mem[read_pointer];
         rd_b_n   = b_mem[read_pointer];
         rd_val_n = 1'b1;
         rd_ill_n = ill_mem[read_pointer];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_opcode    <= '0;
         rd_operand_a <= '0;
         rd_operand_b <= '0;
         rd_valid     <= 1'b0;
         rd_illegal   <= 1'b0;
      end else begin
         rd_opcode    <= rd_op_n;
         rd_operand_a <= rd_a_n;
         rd_operand_b <= rd_b_n;
         rd_valid     <= rd_val_n;
         rd_illegal   <= rd_ill_n;
      end
   end

`ifdef INSTR_REG_RESULT_EN
   localparam int unsigned        RW       = 2 * OP_WIDTH;
   localparam logic [3:0]         OP_ZERO  = 4'd0;
   localparam logic [3:0]         OP_PASSA = 4'd1;
   localparam logic [3:0]         OP_PASSB = 4'd2;
   localparam logic [3:0]         OP_ADD   = 4'd3;
   localparam logic [3:0]         OP_SUB   = 4'd4;
   localparam logic [3:0]         OP_MULT  = 4'd5;
   localparam logic [3:0]         OP_DIV   = 4'd6;
   localparam logic [3:0]         OP_MOD   = 4'd7;
   localparam logic [OP_WIDTH-1:0] MIN_VAL = {1'b1, {(OP_WIDTH-1){1'b0}}};

   logic signed [OP_WIDTH-1:0] a_s;
   logic signed [OP_WIDTH-1:0] b_s;
   logic signed [OP_WIDTH-1:0] quo;
   logic signed [OP_WIDTH-1:0] rem;
   logic                       div_zero;
   logic                       div_ovf;
   logic signed [RW-1:0]       res_c;
   logic        [RW-1:0]       rd_res_n;
   logic        [RW-1:0]       res_mem [DEPTH];

   assign a_s      = operand_a;
   assign b_s      = operand_b;
   assign quo      = a_s / b_s;
   assign rem      = a_s % b_s;
   assign div_zero = (operand_b == '0);
   // MIN / -1 overflows OP_WIDTH; its exact quotient is +2^(OP_WIDTH-1), remainder 0
   assign div_ovf  = (operand_a == MIN_VAL) && (operand_b == '1);

   always_comb begin
      res_c = '0;
      case (opcode)
         OP_ZERO:  res_c = '0;
         OP_PASSA: res_c = RW'(a_s);
         OP_PASSB: res_c = RW'(b_s);
         OP_ADD:   res_c = RW'(a_s) + RW'(b_s);
         OP_SUB:   res_c = RW'(a_s) - RW'(b_s);
         OP_MULT:  res_c = RW'(a_s) * RW'(b_s);
         OP_DIV: begin
            if (!div_zero) begin
               res_c = div_ovf ? -RW'(a_s) : RW'(quo);
            end
         end
         OP_MOD: begin
            if (!div_zero && !div_ovf) begin
               res_c = RW'(rem);
            end
         end
         default:  res_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         res_mem[wr_addr] <= res_c;
      end
   end

   always_comb begin
      rd_res_n = '0;
      if (wr_hit) begin
         rd_res_n = res_c;
      end else if (rd_in_range && valid[read_pointer]) begin
         rd_res_n = res_mem[read_pointer];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_result <= '0;
      end else begin
         rd_result <= rd_res_n;
      end
   end
`else
   assign rd_result = '0;
`endif

endmodule

// File: doc/instr_register_param.md
# instr_register_param

Parametrised successor of the lab instruction register. It stores opcode/operand entries in a DEPTH-deep register file and computes each entry's arithmetic result at write time. It adds per-entry valid tracking, an optional auto-incrementing write pointer and a registered read port. It sits between the testbench interface driver and the future scoreboard, which reads back entries and checks them.

## Interface
- DEPTH, 32: number of entries, 2..256, need not be a power of two.
- OP_WIDTH, 32: signed operand width.
- PTR_WIDTH, $clog2(DEPTH): pointer width, derived, not overridden.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe, sampled on clk.
- auto_inc  in  1  when 1, the write address is next_wr_ptr; when 0, it is write_pointer.
- write_pointer  in  PTR_WIDTH  explicit write address.
- read_pointer  in  PTR_WIDTH  read address.
- opcode  in  4  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD; 8-15 illegal.
- operand_a, operand_b  in  OP_WIDTH  signed operands.
- rd_opcode  out  4  stored opcode.
- rd_operand_a, rd_operand_b  out  OP_WIDTH  stored operands.
- rd_result  out  2*OP_WIDTH  stored signed result.
- rd_valid  out  1  addressed entry written since reset.
- rd_illegal  out  1  addressed entry holds an illegal opcode.
- next_wr_ptr  out  PTR_WIDTH  auto-increment pointer.
- wr_count  out  PTR_WIDTH+1  number of valid entries.

## Operation
- **Write:** on a rising clk with load_en=1 and reset=0, the block stores {opcode, operand_a, operand_b, result, illegal} at the selected address and sets that entry's valid bit.
- **Explicit address out of range:** if the explicit address is ≥ DEPTH, the write is dropped and no state changes.
- **Auto pointer:** a write with auto_inc=1 also advances next_wr_ptr by 1, wrapping from DEPTH-1 to 0. The pointer does not move when auto_inc=0 or load_en=0.
- **wr_count:** increments only when the write targets an entry that is currently invalid. Rewriting a valid entry leaves it unchanged. It saturates naturally at DEPTH.
- **Result, signed, sign-extended to 2*OP_WIDTH:**
  - ZERO gives 0; PASSA gives a; PASSB gives b.
  - ADD gives a+b; SUB gives a-b; MULT gives the full a*b product.
  - DIV gives a/b, truncated toward zero; MOD gives a%b, with the sign of a.
  - DIV or MOD with b=0 gives 0.
  - Illegal opcodes store result 0 with illegal=1.
- **Read:** every rising clk, the rd_* outputs register the entry at read_pointer.
  - read_pointer ≥ DEPTH, or an invalid entry: all rd_* outputs are 0.
- **Same-address write and read on one edge:** write-through. rd_* show the new data, with rd_valid=1.
- **Reset:** all valid bits clear, next_wr_ptr=0, wr_count=0, and every rd_* output is 0. Storage contents are not reset; the valid bits mask them.

## Timing
- Write-to-storage latency: 1 cycle. Read latency: 1 cycle, from read_pointer sampled at edge N to rd_* valid after edge N.
- The result is computed combinationally from the inputs in the write cycle and must close timing at the target frequency for OP_WIDTH=32. It is not pipelined.
- Reset asserts asynchronously and clears outputs immediately. A write on an edge where reset is high is ignored. Deassertion is synchronised externally.
- Reset mid-sequence discards all entries. The first write after reset lands at address 0 when auto_inc=1.
- When the auto pointer wraps, old entries are overwritten and wr_count stays at DEPTH.

## Configuration
- **INSTR_REG_RESULT_EN defined:** the result datapath and per-entry result storage are built, with behaviour as above.
- **INSTR_REG_RESULT_EN undefined:** there is no result storage and rd_result is tied to 0. rd_illegal still works, and all other behaviour is identical.

## Test plan
- **Reset:** assert reset mid-run with 5 entries valid. Outputs go to 0 immediately; wr_count=0 and next_wr_ptr=0. A read of address 3 then gives rd_valid=0.
- **Auto-increment write and read:** write 3 entries with auto_inc=1: ADD 5,-3; MULT -7,6; DIV 9,0. Reading addresses 0, 1 and 2 gives rd_result 2, -42 and 0. Afterwards wr_count=3 and next_wr_ptr=3.
- **Wrap and overwrite:** use DEPTH=4 and perform 6 auto writes. next_wr_ptr=2 and wr_count=4, and addresses 0 and 1 hold the 5th and 6th entries.
- **Explicit address out of range:** use DEPTH=20, auto_inc=0, write_pointer=25. Nothing changes: wr_count is unchanged and no entry is written.
- **Same-address write and read:** write SUB 10,4 to address 7 while read_pointer=7. On the same edge, rd_result=6 and rd_valid=1.
- **Illegal opcode and MOD:** writing opcode 12 gives rd_illegal=1 and rd_result=0. MOD -7,3 gives -1.
